// File: rtl/ls_mem_arbiter.sv
// Load/store sequencer and two-port round-robin arbiter for the data-memory
// path. Drives MAR latch, RAM enable/write-enable and MDR control, then
// returns ack/err and read data to whichever port was granted.
module ls_mem_arbiter #(
    parameter int AW = 4,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [7:0]    addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic          err0,
    input  logic          req1,
    input  logic          we1,
    input  logic [7:0]    addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic          err1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          en_mar,
    output logic [7:0]    mar_addr,
    output logic [1:0]    mdr_ctrl,
    output logic [DW-1:0] mdr_wdata,
    output logic          ram_en,
    output logic          ram_wea,
    input  logic [DW-1:0] ram_rd_data
);

    typedef enum logic [2:0] {IDLE, LATCH, ACCESS, RWAIT, CAPT, ACK} state_t;

    state_t        state;
    logic          last;
    logic          g_port;
    logic          g_we;
    logic          sel_port;
    logic          sel_we;
    logic [7:0]    sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_oor;

    // Round-robin pick among current requesters; only consumed in IDLE
    always_comb begin
        sel_port = 1'b0;
        if (req0 && req1)
            sel_port = ~last;
        else if (req1)
            sel_port = 1'b1;
        sel_we    = sel_port ? we1    : we0;
        sel_addr  = sel_port ? addr1  : addr0;
        sel_wdata = sel_port ? wdata1 : wdata0;
        sel_oor   = (sel_addr >> AW) != 8'd0;
    end

    // Sequencer: every output is registered and set on entry to the state it belongs to
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            g_port    <= 1'b0;
            g_we      <= 1'b0;
            ack0      <= 1'b0;
            err0      <= 1'b0;
            ack1      <= 1'b0;
            err1      <= 1'b0;
            rdata     <= '0;
            busy      <= 1'b0;
            en_mar    <= 1'b0;
            mar_addr  <= '0;
            mdr_ctrl  <= 2'b00;
            mdr_wdata <= '0;
            ram_en    <= 1'b0;
            ram_wea   <= 1'b0;
        end else begin
            ack0      <= 1'b0;
            err0      <= 1'b0;
            ack1      <= 1'b0;
            err1      <= 1'b0;
            en_mar    <= 1'b0;
            mar_addr  <= '0;
            mdr_ctrl  <= 2'b00;
            mdr_wdata <= '0;
            ram_en    <= 1'b0;
            ram_wea   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        g_port <= sel_port;
                        g_we   <= sel_we;
                        busy   <= 1'b1;
                        if (sel_oor) begin
                            // Out-of-range: skip the memory path entirely
                            state <= ACK;
                            rdata <= '0;
                            if (sel_port) begin
                                ack1 <= 1'b1;
                                err1 <= 1'b1;
                            end else begin
                                ack0 <= 1'b1;
                                err0 <= 1'b1;
                            end
                        end else begin
                            state    <= LATCH;
                            en_mar   <= 1'b1;
                            mar_addr <= sel_addr;
                            if (sel_we) begin
                                mdr_ctrl  <= 2'b10;
                                mdr_wdata <= sel_wdata;
                            end
                        end
                    end
                end
                LATCH: begin
                    state   <= ACCESS;
                    ram_en  <= 1'b1;
                    ram_wea <= g_we;
                end
                ACCESS: begin
                    if (g_we) begin
                        state <= ACK;
                        ack0  <= ~g_port;
                        ack1  <= g_port;
                    end else begin
                        state <= RWAIT;
                    end
                end
                RWAIT: begin
                    state    <= CAPT;
                    mdr_ctrl <= 2'b01;
                end
                CAPT: begin
                    state <= ACK;
                    rdata <= ram_rd_data;
                    ack0  <= ~g_port;
                    ack1  <= g_port;
                end
                ACK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    last  <= g_port;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ls_mem_arbiter.sv
// Directed bench for ls_mem_arbiter with a small MAR/MDR/RAM environment.
module tb_ls_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, we0, req1, we1;
    logic [7:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, err0, ack1, err1;
    logic [15:0] rdata;
    logic        busy, en_mar, ram_en, ram_wea;
    logic [7:0]  mar_addr;
    logic [1:0]  mdr_ctrl;
    logic [15:0] mdr_wdata;
    logic [15:0] ram_rd_data;

    int checks = 0;
    int errors = 0;

    ls_mem_arbiter #(.AW(4), .DW(16)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .err0(err0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .err1(err1),
        .rdata(rdata), .busy(busy), .en_mar(en_mar), .mar_addr(mar_addr),
        .mdr_ctrl(mdr_ctrl), .mdr_wdata(mdr_wdata), .ram_en(ram_en), .ram_wea(ram_wea),
        .ram_rd_data(ram_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment: MAR, MDR and a 16-word RAM with one-cycle read latency
    logic [7:0]  mar_q;
    logic [15:0] mdr_q;
    logic [15:0] mem [16];
    logic        mem_init;

    always @(posedge clk) begin
        if (!rst && !mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'h1000 + 16'(i);
            mem_init    <= 1'b1;
            mar_q       <= '0;
            mdr_q       <= '0;
            ram_rd_data <= '0;
        end else begin
            if (en_mar) mar_q <= mar_addr;
            if (mdr_ctrl == 2'b10) mdr_q <= mdr_wdata;
            if (ram_en) begin
                if (ram_wea) mem[mar_q[3:0]] <= mdr_q;
                else         ram_rd_data <= mem[mar_q[3:0]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ctl"}, {24'd0, ack0, err0, ack1, err1, en_mar, ram_en, ram_wea, busy}, 32'd0);
        chk({tag, "_mdr"}, {30'd0, mdr_ctrl}, 32'd0);
        chk({tag, "_mar"}, {24'd0, mar_addr}, 32'd0);
        chk({tag, "_rd"}, {16'd0, rdata}, 32'd0);
    endtask

    // Waits for the ack of 'port' (bounded) and checks latency, err and rdata
    task automatic wait_ack(input int port, input int exp_cyc, input logic exp_err,
                            input logic chk_rd, input logic [15:0] exp_rd, input string tag);
        int  n;
        logic got;
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            tick();
            n++;
            chk({tag, "_other_ack"}, (port == 0) ? ack1 : ack0, 1'b0);
            if ((port == 0) ? ack0 : ack1) got = 1'b1;
        end
        chk({tag, "_lat"}, n, exp_cyc);
        chk({tag, "_err"}, (port == 0) ? err0 : err1, exp_err);
        if (chk_rd) chk({tag, "_rdata"}, rdata, exp_rd);
        if (port == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    int          ord [4];
    int          cyc [4];
    logic [15:0] rdv [4];
    int          nack;
    int          n;

    initial begin
        mem_init = 1'b0;
        rst = 1'b0;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        tick(); tick();
        chk_quiet("reset");
        rst = 1'b1;
        tick();

        // Port-0 write addr 3
        req0 = 1; we0 = 1; addr0 = 8'd3; wdata0 = 16'hA5A5;
        tick();
        chk("w_latch_en_mar", en_mar, 1'b1);
        chk("w_latch_mar_addr", mar_addr, 8'd3);
        chk("w_latch_mdr_ctrl", mdr_ctrl, 2'b10);
        chk("w_latch_mdr_wdata", mdr_wdata, 16'hA5A5);
        chk("w_latch_busy", busy, 1'b1);
        tick();
        chk("w_access_ram", {en_mar, ram_en, ram_wea}, 3'b011);
        tick();
        chk("w_ack", {ack0, err0, ack1}, 3'b100);
        req0 = 0;
        tick();
        chk("w_idle", {ack0, busy}, 2'b00);

        // Port-0 read addr 3
        req0 = 1; we0 = 0; addr0 = 8'd3;
        tick();
        chk("r_latch", {en_mar, mar_addr, mdr_ctrl}, {1'b1, 8'd3, 2'b00});
        tick();
        chk("r_access_ram", {ram_en, ram_wea}, 2'b10);
        tick();
        chk("r_rwait", {ack0, en_mar, ram_en, mdr_ctrl}, 5'b0);
        tick();
        chk("r_capt_mdr", mdr_ctrl, 2'b01);
        tick();
        chk("r_ack", {ack0, err0}, 2'b10);
        chk("r_rdata", rdata, 16'hA5A5);
        req0 = 0;
        tick();

        // Fresh reset, then both ports hold read requests
        rst = 0; tick(); rst = 1; tick();
        req0 = 1; we0 = 0; addr0 = 8'd1;
        req1 = 1; we1 = 0; addr1 = 8'd2;
        nack = 0; n = 0;
        while (nack < 4 && n < 40) begin
            tick();
            n++;
            chk("rr_no_dual_ack", ack0 & ack1, 1'b0);
            if (ack0 || ack1) begin
                ord[nack] = ack1 ? 1 : 0;
                cyc[nack] = n;
                rdv[nack] = rdata;
                nack++;
            end
        end
        req0 = 0; req1 = 0;
        chk("rr_count", nack, 4);
        chk("rr_order", {ord[0][0], ord[1][0], ord[2][0], ord[3][0]}, 4'b0101);
        chk("rr_cycles", {cyc[0][7:0], cyc[1][7:0], cyc[2][7:0], cyc[3][7:0]},
            {8'd5, 8'd11, 8'd17, 8'd23});
        chk("rr_rdata_p0", rdv[0], 16'h1001);
        chk("rr_rdata_p1", rdv[1], 16'h1002);
        tick();

        // Out-of-range port-1 read
        req1 = 1; we1 = 0; addr1 = 8'h10;
        tick();
        chk("oor1_ack", {ack1, err1, ack0}, 3'b110);
        chk("oor1_rdata", rdata, 16'h0000);
        chk("oor1_quiet", {en_mar, ram_en, mdr_ctrl}, 4'b0);
        req1 = 0;
        tick();
        chk("oor1_after", {ack1, err1, en_mar, ram_en, mdr_ctrl, busy}, 7'b0);
        tick();

        // Out-of-range port-0 write (leaves last = 0)
        req0 = 1; we0 = 1; addr0 = 8'h80; wdata0 = 16'hFFFF;
        wait_ack(0, 1, 1'b1, 1'b1, 16'h0000, "oor0");
        chk("oor0_mdr", mdr_ctrl, 2'b00);
        tick();

        // Reset during RWAIT of a port-0 read
        req0 = 1; we0 = 0; addr0 = 8'd2;
        tick(); tick(); tick();
        chk("abort_rwait", {ack0, busy}, 2'b01);
        rst = 0; req0 = 0;
        tick();
        chk_quiet("abort_reset");
        rst = 1;
        tick();
        chk("abort_no_ack", {ack0, ack1, busy}, 3'b000);
        req0 = 1; we0 = 0; addr0 = 8'd2;
        req1 = 1; we1 = 0; addr1 = 8'd1;
        tick();
        chk("post_rst_grant_mar", mar_addr, 8'd2);
        wait_ack(0, 4, 1'b0, 1'b1, 16'h1002, "post_rst_p0");
        wait_ack(1, 6, 1'b0, 1'b1, 16'h1001, "post_rst_p1");
        tick();

        // Port-1 write to top address, port-0 reads it back
        req1 = 1; we1 = 1; addr1 = 8'd15; wdata1 = 16'h5A3C;
        wait_ack(1, 3, 1'b0, 1'b0, 16'h0000, "p1_w15");
        tick();
        req0 = 1; we0 = 0; addr0 = 8'd15;
        wait_ack(0, 5, 1'b0, 1'b1, 16'h5A3C, "p0_r15");
        tick();
        chk("end_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
